// File: rtl/bcd_mode_timer_pkg.sv
// bcd_mode_timer_pkg: shared state encoding, count-direction constants and the BCD conversion used at elaboration.
package bcd_mode_timer_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE} state_t;

    localparam logic MODE_UP   = 1'b0;
    localparam logic MODE_DOWN = 1'b1;

    // Packs up to 16 decimal digits, digit 0 in the low nibble.
    function automatic logic [63:0] bin2bcd(input int unsigned v);
        logic [63:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < 16; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_updown.sv
// bcd_digit_updown: one loadable BCD digit stepping up or down, flagging its wrap so the next digit can follow.
module bcd_digit_updown (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       dir,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] digit,
    output logic       carry_out,
    output logic       borrow_out
);

    assign carry_out  = en && !dir && digit == 4'd9;
    assign borrow_out = en && dir && digit == 4'd0;

    always_ff @(posedge clk) begin
        if (rst)
            digit <= '0;
        else if (load)
            digit <= load_val;
        else if (en)
            digit <= dir ? (digit == 4'd0 ? 4'd9 : digit - 4'd1)
                         : (digit == 4'd9 ? 4'd0 : digit + 4'd1);
    end

endmodule

// File: rtl/bcd_mode_timer.sv
// bcd_mode_timer: N-digit BCD up/down timer with tick prescaler, run/pause/done control and optional auto-reload.
module bcd_mode_timer
    import bcd_mode_timer_pkg::*;
#(
    parameter int DIGITS      = 2,
    parameter int MAX_VAL     = 99,
    parameter int TICK_DIV    = 100,
    parameter int AUTO_RELOAD = 0
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                ModeSel,
    input  logic                Start,
    input  logic                Stop,
    input  logic                Clear,
    output logic [4*DIGITS-1:0] CountOut,
    output logic                Running,
    output logic                Done
);

    localparam int W  = 4 * DIGITS;
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [63:0]   MAX_FULL = bin2bcd(MAX_VAL);
    localparam logic [63:0]   PRE_FULL = bin2bcd(MAX_VAL - 1);
    localparam logic [W-1:0]  MAX_BCD  = MAX_FULL[W-1:0];
    localparam logic [W-1:0]  PRE_UP   = PRE_FULL[W-1:0];
    localparam logic [W-1:0]  PRE_DN   = W'(1);
    localparam logic [PW-1:0] LAST     = PW'(TICK_DIV - 1);

    state_t          state;
    logic            mode;
    logic [PW-1:0]   presc;
    logic            tick, run_go, reload, step, hit, load;
    logic [W-1:0]    load_val;
    logic [DIGITS:0] en;
    logic [DIGITS-1:0] cy, bw;
    logic            unused_top;

    assign tick    = presc == LAST;
    assign run_go  = state == ST_RUN && !Clear && !Stop;
    // Only reachable with auto-reload: a run sitting on its terminal value reloads on the next tick.
    assign reload  = run_go && tick && AUTO_RELOAD != 0
                     && CountOut == (mode == MODE_UP ? MAX_BCD : '0);
    assign step    = run_go && tick && !reload;
    // Terminal is detected one step early so Done lines up with the terminal value appearing.
    assign hit     = step && CountOut == (mode == MODE_UP ? PRE_UP : PRE_DN);
    assign load    = Clear || state == ST_IDLE || (state == ST_DONE && Start && !Stop) || reload;
    assign load_val = ((reload ? mode : ModeSel) == MODE_DOWN) ? MAX_BCD : '0;
    assign Running = state == ST_RUN;

    assign en[0]      = step;
    assign unused_top = en[DIGITS];

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_updown u_digit (
            .clk       (Clk),
            .rst       (Reset),
            .en        (en[g]),
            .dir       (mode),
            .load      (load),
            .load_val  (load_val[4*g +: 4]),
            .digit     (CountOut[4*g +: 4]),
            .carry_out (cy[g]),
            .borrow_out(bw[g])
        );
        assign en[g+1] = cy[g] | bw[g];
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= ST_IDLE;
            mode  <= MODE_UP;
            presc <= '0;
            Done  <= 1'b0;
        end else begin
            Done <= hit;
            if (Clear) begin
                state <= ST_IDLE;
                presc <= '0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE:
                        if (Start && !Stop) begin
                            state <= ST_RUN;
                            mode  <= ModeSel;
                            presc <= '0;
                        end
                    ST_RUN:
                        if (Stop)
                            state <= ST_PAUSE;
                        else begin
                            presc <= tick ? '0 : presc + 1'b1;
                            if (hit && AUTO_RELOAD == 0)
                                state <= ST_DONE;
                        end
                    ST_PAUSE:
                        if (Start && !Stop)
                            state <= ST_RUN;
                    default:
                        state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
